// File: rtl/sd_bus_arbiter.sv
// sd_bus_arbiter: grants the SD SPI bus to the init, read or write engine, with idle gaps between owners and a per-grant watchdog.
module sd_bus_arbiter #(
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic SD_CK,
  input  logic rst,
  input  logic init_req,
  input  logic rd_req,
  input  logic wr_req,
  input  logic init_done,
  input  logic rd_done,
  input  logic wr_done,
  input  logic init_MOSI,
  input  logic rd_MOSI,
  input  logic wr_MOSI,
  input  logic init_CSn,
  input  logic rd_CSn,
  input  logic wr_CSn,
  output logic init_gnt,
  output logic rd_gnt,
  output logic wr_gnt,
  output logic SD_MOSI,
  output logic SD_CSn,
  output logic card_ready,
  output logic timeout,
  output logic busy
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  typedef enum logic [2:0] {IDLE, INIT, RD, WR, GAP} state_t;
  state_t state, state_nx, idle_sel;
  logic [WW-1:0] wd;
  logic [GW-1:0] gap;
  logic last_wr, granted, own_done, expire;
  always_comb begin
    granted  = state == INIT || state == RD || state == WR;
    own_done = (state == INIT && init_done) || (state == RD && rd_done) || (state == WR && wr_done);
    // done in the expiry cycle wins over the watchdog
    expire   = granted && wd == WW'(TIMEOUT_CYCLES - 1) && !own_done;
    idle_sel = (!card_ready && init_req) ? INIT :
               (card_ready && rd_req && (!wr_req || last_wr)) ? RD :
               (card_ready && wr_req) ? WR : IDLE;
    state_nx = state == IDLE ? idle_sel :
               state == GAP ? (gap <= GW'(1) ? IDLE : GAP) :
               (own_done || expire) ? GAP : state;
  end
  always_ff @(posedge SD_CK) begin
    if (rst) begin
      state      <= IDLE;
      card_ready <= 1'b0;
      timeout    <= 1'b0;
      last_wr    <= 1'b1;
      wd         <= '0;
      gap        <= '0;
    end else begin
      state      <= state_nx;
      timeout    <= expire;
      card_ready <= card_ready | (state == INIT && init_done);
      last_wr    <= state_nx == WR ? 1'b1 : state_nx == RD ? 1'b0 : last_wr;
      wd         <= (granted && state_nx == state) ? wd + 1'b1 : '0;
      gap        <= (granted && state_nx == GAP) ? GW'(GAP_CYCLES) :
                    (state == GAP && gap != '0) ? gap - 1'b1 : gap;
    end
  end
  assign init_gnt = state == INIT;
  assign rd_gnt   = state == RD;
  assign wr_gnt   = state == WR;
  assign busy     = state != IDLE;
  assign SD_MOSI  = init_gnt ? init_MOSI : rd_gnt ? rd_MOSI : wr_gnt ? wr_MOSI : 1'b1;
  assign SD_CSn   = init_gnt ? init_CSn : rd_gnt ? rd_CSn : wr_gnt ? wr_CSn : 1'b1;
endmodule

// File: tb/tb_sd_bus_arbiter.sv
// tb_sd_bus_arbiter: directed bench with a grant-order scoreboard; dut uses default timeout, t_dut a 16-cycle one.
module tb_sd_bus_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic init_req = 0, rd_req = 0, wr_req = 0, init_done = 0, rd_done = 0, wr_done = 0;
  logic init_MOSI = 1, rd_MOSI = 1, wr_MOSI = 1, init_CSn = 1, rd_CSn = 1, wr_CSn = 1;
  logic init_gnt, rd_gnt, wr_gnt, SD_MOSI, SD_CSn, card_ready, timeout, busy;
  logic t_init_gnt, t_rd_gnt, t_wr_gnt, t_SD_MOSI, t_SD_CSn, t_card_ready, t_timeout, t_busy;
  int checks = 0, errors = 0;
  logic [2:0] sb[$];
  logic [2:0] exp_o;
  int n, cb, g, tc;

  always #5 clk = ~clk;

  sd_bus_arbiter dut (
    .SD_CK(clk), .rst(rst), .init_req(init_req), .rd_req(rd_req), .wr_req(wr_req),
    .init_done(init_done), .rd_done(rd_done), .wr_done(wr_done),
    .init_MOSI(init_MOSI), .rd_MOSI(rd_MOSI), .wr_MOSI(wr_MOSI),
    .init_CSn(init_CSn), .rd_CSn(rd_CSn), .wr_CSn(wr_CSn),
    .init_gnt(init_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
    .SD_MOSI(SD_MOSI), .SD_CSn(SD_CSn), .card_ready(card_ready), .timeout(timeout), .busy(busy)
  );

  sd_bus_arbiter #(.GAP_CYCLES(8), .TIMEOUT_CYCLES(16)) t_dut (
    .SD_CK(clk), .rst(rst), .init_req(init_req), .rd_req(rd_req), .wr_req(wr_req),
    .init_done(init_done), .rd_done(rd_done), .wr_done(wr_done),
    .init_MOSI(init_MOSI), .rd_MOSI(rd_MOSI), .wr_MOSI(wr_MOSI),
    .init_CSn(init_CSn), .rd_CSn(rd_CSn), .wr_CSn(wr_CSn),
    .init_gnt(t_init_gnt), .rd_gnt(t_rd_gnt), .wr_gnt(t_wr_gnt),
    .SD_MOSI(t_SD_MOSI), .SD_CSn(t_SD_CSn), .card_ready(t_card_ready), .timeout(t_timeout), .busy(t_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] gv(input bit t);
    return t ? {t_init_gnt, t_rd_gnt, t_wr_gnt} : {init_gnt, rd_gnt, wr_gnt};
  endfunction

  function automatic logic csn(input bit t);
    return t ? t_SD_CSn : SD_CSn;
  endfunction

  // counts non-granted cycles (and any CSn=0 among them) until a grant appears
  task automatic wait_grant(input bit t, output int cycles, output int bad);
    cycles = 0;
    bad = 0;
    while (gv(t) == 3'b000 && cycles < 200) begin
      if (csn(t) !== 1'b1) bad++;
      tick();
      cycles++;
    end
  endtask

  task automatic wait_idle(input bit t, output int cycles, output int bad);
    cycles = 0;
    bad = 0;
    while ((t ? t_busy : busy) && cycles < 200) begin
      if (csn(t) !== 1'b1) bad++;
      tick();
      cycles++;
    end
  endtask

  initial begin
    tick();
    rst = 1'b0;
    chk("rst_gnt", gv(0), 3'b000);
    chk("rst_ready", card_ready, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_csn", SD_CSn, 1);
    chk("rst_mosi", SD_MOSI, 1);
    // read request before the card is ready must be ignored
    rd_req = 1;
    cb = 0;
    repeat (50) begin
      tick();
      if (rd_gnt || SD_CSn !== 1'b1 || busy) cb++;
    end
    rd_req = 0;
    chk("noready_rd", cb, 0);
    // init sequence
    init_req = 1; init_CSn = 0; init_MOSI = 0; rd_CSn = 0; rd_MOSI = 1;
    sb.push_back(3'b100);
    wait_grant(0, n, cb);
    exp_o = sb.pop_front();
    chk("init_owner", gv(0), exp_o);
    chk("init_latency", n, 1);
    chk("init_csn", SD_CSn, 0);
    chk("init_mosi", SD_MOSI, 0);
    repeat (19) tick();
    init_done = 1; init_req = 0;
    tick();
    init_done = 0;
    chk("init_ready", card_ready, 1);
    chk("init_gnt_drop", gv(0), 3'b000);
    wait_idle(0, g, cb);
    chk("init_gap_len", g, 8);
    chk("init_gap_csn", cb, 0);
    // alternating read/write arbitration
    rd_req = 1; wr_req = 1; rd_CSn = 0; wr_CSn = 0; rd_MOSI = 0; wr_MOSI = 1;
    sb.push_back(3'b010); sb.push_back(3'b001); sb.push_back(3'b010);
    for (int k = 0; k < 3; k++) begin
      wait_grant(0, n, cb);
      exp_o = sb.pop_front();
      chk("alt_owner", gv(0), exp_o);
      chk("alt_turnaround", n, k == 0 ? 1 : 10 - 1);
      chk("alt_gap_csn", cb, 0);
      chk("alt_mosi", SD_MOSI, exp_o[0]);
      chk("alt_csn", SD_CSn, 0);
      repeat (9) tick();
      if (k == 2) begin rd_req = 0; wr_req = 0; end
      rd_done = exp_o[1]; wr_done = exp_o[0];
      tick();
      rd_done = 0; wr_done = 0;
    end
    wait_idle(0, g, cb);
    chk("alt_final_gap", g, 8);
    // second instance: 16-cycle watchdog
    rst = 1;
    tick();
    rst = 0;
    chk("t_rst_gnt", gv(1), 3'b000);
    chk("t_rst_ready", t_card_ready, 0);
    init_req = 1; init_CSn = 1;
    sb.push_back(3'b100);
    wait_grant(1, n, cb);
    exp_o = sb.pop_front();
    chk("t_init_owner", gv(1), exp_o);
    repeat (2) tick();
    init_done = 1; init_req = 0;
    tick();
    init_done = 0;
    wait_idle(1, g, cb);
    chk("t_ready", t_card_ready, 1);
    // write grant held without done is revoked by the watchdog
    wr_req = 1;
    sb.push_back(3'b001);
    wait_grant(1, n, cb);
    exp_o = sb.pop_front();
    chk("wd_owner", gv(1), exp_o);
    chk("wd_latency", n, 1);
    wr_req = 0;
    g = 0; tc = 0;
    while (t_wr_gnt && g < 100) begin
      g++;
      tick();
      tc += int'(t_timeout);
    end
    chk("wd_timeout_now", t_timeout, 1);
    repeat (12) begin
      tick();
      tc += int'(t_timeout);
    end
    chk("wd_grant_len", g, 16);
    chk("wd_pulses", tc, 1);
    chk("wd_ready_kept", t_card_ready, 1);
    chk("wd_idle", t_busy, 0);
    // done coinciding with watchdog expiry; foreign done ignored
    rd_req = 1;
    sb.push_back(3'b010);
    wait_grant(1, n, cb);
    exp_o = sb.pop_front();
    chk("dw_owner", gv(1), exp_o);
    repeat (3) tick();
    wr_done = 1;
    tick();
    wr_done = 0;
    chk("foreign_done", t_rd_gnt, 1);
    repeat (11) tick();
    rd_done = 1; rd_req = 0;
    tick();
    rd_done = 0;
    chk("dw_gnt_drop", t_rd_gnt, 0);
    chk("dw_no_timeout", t_timeout, 0);
    chk("dw_gap", t_busy, 1);
    tc = 0;
    g = 0;
    while (t_busy && g < 100) begin
      tc += int'(t_timeout);
      g++;
      tick();
    end
    chk("dw_gap_len", g, 8);
    chk("dw_no_timeout_gap", tc, 0);
    // reset during a read grant
    rd_req = 1; rd_MOSI = 0; rd_CSn = 0;
    sb.push_back(3'b010);
    wait_grant(1, n, cb);
    exp_o = sb.pop_front();
    chk("rr_owner", gv(1), exp_o);
    repeat (3) tick();
    chk("rr_csn_pre", t_SD_CSn, 0);
    chk("rr_mosi_pre", t_SD_MOSI, 0);
    rst = 1;
    tick();
    chk("rr_csn", t_SD_CSn, 1);
    chk("rr_mosi", t_SD_MOSI, 1);
    chk("rr_gnt", t_rd_gnt, 0);
    chk("rr_ready", t_card_ready, 0);
    chk("rr_timeout", t_timeout, 0);
    chk("rr_busy", t_busy, 0);
    rst = 0; rd_req = 0;
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
